// File: rtl/serializador_tx.sv
// serializador_tx: transmit-side parallel-to-serial stage.
// Buffers bytes in a small FIFO and shifts them out MSB first in fixed
// 8-clock frames. Before any payload, a preamble of comma bytes is sent
// so the downstream receiver can lock on. Whenever no payload is pending,
// the comma byte fills the idle frames.
module serializador_tx #(
    parameter logic [7:0] COMMA  = 8'hBC,
    parameter int         N_SYNC = 4,
    parameter int         DEPTH  = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       push,
    output logic       full,
    output logic       overflow,
    output logic       data_out,
    output logic       tx_data,
    output logic       sync_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_SYNC + 1);

    typedef enum logic {
        SYNC = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q;
    logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            data_out_q, data_out_d;
    logic            tx_data_q, tx_data_d;
    logic            sync_done_q, sync_done_d;
    logic            overflow_q;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;

    logic            load;
    logic            pop;
    logic            push_acc;
    logic [7:0]      byte_sel;

    assign load     = (bit_cnt_q == 3'd0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    // A full FIFO still accepts a byte if the head leaves on the same edge.
    assign push_acc = push && (!full || pop);

    assign data_out  = data_out_q;
    assign tx_data   = tx_data_q;
    assign sync_done = sync_done_q;
    assign overflow  = overflow_q;

    // Frame FSM: picks the byte for each load edge and drives the shifter.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        sync_done_d = sync_done_q;
        tx_data_d   = tx_data_q;
        pop         = 1'b0;
        byte_sel    = COMMA;
        data_out_d  = shift_q[7];
        shift_d     = {shift_q[6:0], 1'b0};
        if (load) begin
            case (state_q)
                SYNC: begin
                    tx_data_d   = 1'b0;
                    comma_cnt_d = comma_cnt_q + CW'(1);
                    if (comma_cnt_q == CW'(N_SYNC - 1)) begin
                        state_d     = DATA;
                        sync_done_d = 1'b1;
                    end
                end
                DATA: begin
                    if (count_q != '0) begin
                        byte_sel  = mem_q[rd_ptr_q];
                        pop       = 1'b1;
                        tx_data_d = 1'b1;
                    end else begin
                        tx_data_d = 1'b0;
                    end
                end
                default: state_d = SYNC;
            endcase
            data_out_d = byte_sel[7];
            shift_d    = {byte_sel[6:0], 1'b0};
        end
    end

    // FIFO occupancy follows accepted pushes and pops.
    always_comb begin
        count_d = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control, shifter and FIFO pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= SYNC;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= '0;
            shift_q     <= 8'h00;
            data_out_q  <= 1'b0;
            tx_data_q   <= 1'b0;
            sync_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_q + 3'd1;
            comma_cnt_q <= comma_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            tx_data_q   <= tx_data_d;
            sync_done_q <= sync_done_d;
            count_q     <= count_d;
            if (push && !push_acc) begin
                overflow_q <= 1'b1;
            end
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_32f) begin
        if (reset && push_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_serializador_tx.sv
// Testbench for serializador_tx: directed scenarios plus random traffic,
// compared every edge against a frame-level reference model.
module tb_serializador_tx;

    localparam logic [7:0] COMMA  = 8'hBC;
    localparam int         N_SYNC = 4;
    localparam int         DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       push = 1'b0;
    logic       full, overflow, data_out, tx_data, sync_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q[$];
    int         e = 0;
    logic [7:0] frame = 8'h00;
    logic       exp_do = 1'b0, exp_tx = 1'b0, exp_sd = 1'b0, exp_ovf = 1'b0, exp_full = 1'b0;

    always #5 clk = ~clk;

    serializador_tx #(.COMMA(COMMA), .N_SYNC(N_SYNC), .DEPTH(DEPTH)) dut (
        .clk_32f   (clk),
        .reset     (rst_n),
        .data_in   (din),
        .push      (push),
        .full      (full),
        .overflow  (overflow),
        .data_out  (data_out),
        .tx_data   (tx_data),
        .sync_done (sync_done)
    );

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
        end
    endtask

    // Advance the model by one edge using the inputs seen at that edge.
    task automatic model_step(input logic r, input logic p, input logic [7:0] d);
        int  phase;
        bit  popped;
        if (!r) begin
            q.delete();
            e = 0; frame = 8'h00;
            exp_do = 0; exp_tx = 0; exp_sd = 0; exp_ovf = 0;
        end else begin
            phase  = e % 8;
            popped = 0;
            if (phase == 0) begin
                if (e < 8 * N_SYNC) begin
                    frame = COMMA; exp_tx = 0;
                end else if (q.size() > 0) begin
                    frame = q.pop_front(); exp_tx = 1; popped = 1;
                end else begin
                    frame = COMMA; exp_tx = 0;
                end
            end
            if (p) begin
                if (q.size() < DEPTH || popped) q.push_back(d);
                else exp_ovf = 1;
            end
            exp_do = frame[7 - phase];
            exp_sd = (e >= 8 * (N_SYNC - 1));
            e++;
        end
        exp_full = (q.size() == DEPTH);
    endtask

    task automatic tick(input logic r, input logic p, input logic [7:0] d);
        rst_n = r; push = p; din = d;
        @(posedge clk);
        #1;
        model_step(r, p, d);
        check("data_out", data_out, exp_do);
        check("tx_data", tx_data, exp_tx);
        check("sync_done", sync_done, exp_sd);
        check("full", full, exp_full);
        check("overflow", overflow, exp_ovf);
        push = 0;
    endtask

    task automatic idle_until(input int edge_n);
        while (e < edge_n) tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int rate;
        // Reset and preamble, then a single byte pushed at edge 40.
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        idle_until(40);
        tick(1'b1, 1'b1, 8'hA5);
        idle_until(72);

        // Pushes during SYNC at edges 3 and 4.
        tick(1'b0, 1'b0, 8'h00);
        idle_until(3);
        tick(1'b1, 1'b1, 8'h01);
        tick(1'b1, 1'b1, 8'h02);
        idle_until(56);

        // Back-to-back fill, overflow, full+pop at edge 40, reset at edge 51.
        tick(1'b0, 1'b0, 8'h00);
        idle_until(33);
        tick(1'b1, 1'b1, 8'h11);
        tick(1'b1, 1'b1, 8'h22);
        tick(1'b1, 1'b1, 8'h33);
        tick(1'b1, 1'b1, 8'h44);
        tick(1'b1, 1'b1, 8'h55);
        idle_until(40);
        tick(1'b1, 1'b1, 8'h66);
        idle_until(51);
        tick(1'b0, 1'b0, 8'h00);
        idle_until(80);

        // Random traffic with varying push density and rare resets.
        for (int blk = 0; blk < 15; blk++) begin
            rate = (blk % 3 == 0) ? 12 : ((blk % 3 == 1) ? 60 : 25);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 999) == 0)
                    tick(1'b0, 1'b0, 8'h00);
                else
                    tick(1'b1, ($urandom_range(0, 99) < rate), 8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
